// File: rtl/pipe_stage_reg.sv
// Reusable inter-stage pipeline register: main register M plus a one-entry skid
// buffer S under a valid/ready handshake, with flush-to-bubble and a stall counter.
module pipe_stage_reg #(
   parameter int unsigned PAYLOAD_W     = 192,
   parameter int unsigned INSTR_W       = 32,
   parameter int unsigned PC_W          = 32,
   parameter int unsigned FLUSH_KEEP_PC = 1,
   parameter int unsigned CNT_W         = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [INSTR_W-1:0]   in_instr,
   input  logic [PC_W-1:0]      in_pc,
   input  logic [PAYLOAD_W-1:0] in_payload,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [INSTR_W-1:0]   out_instr,
   output logic [PC_W-1:0]      out_pc,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic [CNT_W-1:0]     stall_cnt
);

   logic                 m_valid;
   logic [INSTR_W-1:0]   m_instr;
   logic [PC_W-1:0]      m_pc;
   logic [PAYLOAD_W-1:0] m_payload;

   logic                 s_valid;
   logic [INSTR_W-1:0]   s_instr;
   logic [PC_W-1:0]      s_pc;
   logic [PAYLOAD_W-1:0] s_payload;

   logic acc;
   logic drain;

   // Ready depends only on skid occupancy, so out_ready never reaches in_ready.
   assign in_ready = ~s_valid;
   assign acc      = in_valid & ~s_valid;
   assign drain    = m_valid & out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         m_valid   <= 1'b0;
         m_instr   <= '0;
         m_pc      <= '0;
         m_payload <= '0;
         s_valid   <= 1'b0;
         s_instr   <= '0;
         s_pc      <= '0;
         s_payload <= '0;
      end else if (flush) begin
         m_valid   <= 1'b0;
         m_instr   <= '0;
         m_payload <= '0;
         m_pc      <= (FLUSH_KEEP_PC != 0) ? m_pc : '0;
         s_valid   <= 1'b0;
      end else if (!m_valid || drain) begin
         if (s_valid) begin
            m_valid   <= 1'b1;
            m_instr   <= s_instr;
            m_pc      <= s_pc;
            m_payload <= s_payload;
            s_valid   <= acc;
            if (acc) begin
               s_instr   <= in_instr;
               s_pc      <= in_pc;
               s_payload <= in_payload;
            end
         end else if (acc) begin
            m_valid   <= 1'b1;
            m_instr   <= in_instr;
            m_pc      <= in_pc;
            m_payload <= in_payload;
         end else begin
            // Bubble: instr forced to NOP, pc/payload keep the last entry.
            m_valid <= 1'b0;
            m_instr <= '0;
         end
      end else if (acc) begin
         s_valid   <= 1'b1;
         s_instr   <= in_instr;
         s_pc      <= in_pc;
         s_payload <= in_payload;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (m_valid && !out_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign out_valid   = m_valid;
   assign out_instr   = m_instr;
   assign out_pc      = m_pc;
   assign out_payload = m_payload;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two configurations driven in lockstep, checked by a
// directed table, hand sequences and a queue-based reference model.
module tb_pipe_stage_reg;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [31:0]   in_instr;
   logic [31:0]   in_pc;
   logic [191:0]  in_payload;
   logic          flush;
   logic          out_ready;

   logic          in_ready0, out_valid0;
   logic [31:0]   out_instr0, out_pc0;
   logic [191:0]  out_payload0;
   logic [3:0]    stall_cnt0;

   logic          in_ready1, out_valid1;
   logic [31:0]   out_instr1, out_pc1;
   logic [0:0]    out_payload1;
   logic [15:0]   stall_cnt1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.PAYLOAD_W(192), .INSTR_W(32), .PC_W(32), .FLUSH_KEEP_PC(1), .CNT_W(4)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
      .in_instr(in_instr), .in_pc(in_pc), .in_payload(in_payload), .flush(flush),
      .out_valid(out_valid0), .out_ready(out_ready), .out_instr(out_instr0),
      .out_pc(out_pc0), .out_payload(out_payload0), .stall_cnt(stall_cnt0)
   );

   pipe_stage_reg #(.PAYLOAD_W(1), .INSTR_W(32), .PC_W(32), .FLUSH_KEEP_PC(0), .CNT_W(16)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
      .in_instr(in_instr), .in_pc(in_pc), .in_payload(in_payload[0:0]), .flush(flush),
      .out_valid(out_valid1), .out_ready(out_ready), .out_instr(out_instr1),
      .out_pc(out_pc1), .out_payload(out_payload1), .stall_cnt(stall_cnt1)
   );

   // Reference model: the stage is a FIFO of at most two entries.
   typedef struct {
      logic [31:0]  instr;
      logic [31:0]  pc;
      logic [191:0] pay;
   } ent_t;

   ent_t         q[$];
   logic [31:0]  disp_pc0, disp_pc1;
   logic [191:0] disp_pay;
   int           cnt0, cnt1;

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return {~pc[15:0], pc[15:0]};
   endfunction

   task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_update();
      ent_t e;
      if (reset) begin
         q.delete();
         disp_pc0 = '0;
         disp_pc1 = '0;
         disp_pay = '0;
         cnt0 = 0;
         cnt1 = 0;
      end else begin
         if (q.size() > 0 && !out_ready) begin
            if (cnt0 < 15)    cnt0++;
            if (cnt1 < 65535) cnt1++;
         end
         if (flush) begin
            disp_pc0 = (q.size() > 0) ? q[0].pc : disp_pc0;
            disp_pc1 = '0;
            disp_pay = '0;
            q.delete();
         end else begin
            bit dr, ac;
            dr = (q.size() > 0) && out_ready;
            ac = in_valid && (q.size() < 2);
            if (dr) begin
               disp_pc0 = q[0].pc;
               disp_pc1 = q[0].pc;
               disp_pay = q[0].pay;
               void'(q.pop_front());
            end
            if (ac) begin
               e.instr = in_instr;
               e.pc    = in_pc;
               e.pay   = in_payload;
               q.push_back(e);
            end
         end
      end
   endtask

   task automatic model_check();
      bit           ev;
      logic [31:0]  ei, ep0, ep1;
      logic [191:0] epay;
      ev   = q.size() > 0;
      ei   = ev ? q[0].instr : 32'h0;
      ep0  = ev ? q[0].pc : disp_pc0;
      ep1  = ev ? q[0].pc : disp_pc1;
      epay = ev ? q[0].pay : disp_pay;
      chk("m0_valid", {191'b0, out_valid0}, {191'b0, ev});
      chk("m0_ready", {191'b0, in_ready0}, {191'b0, q.size() < 2});
      chk("m0_instr", {160'b0, out_instr0}, {160'b0, ei});
      chk("m0_pc", {160'b0, out_pc0}, {160'b0, ep0});
      chk("m0_payload", out_payload0, epay);
      chk("m0_stall", {188'b0, stall_cnt0}, 192'(cnt0));
      chk("m1_valid", {191'b0, out_valid1}, {191'b0, ev});
      chk("m1_ready", {191'b0, in_ready1}, {191'b0, q.size() < 2});
      chk("m1_instr", {160'b0, out_instr1}, {160'b0, ei});
      chk("m1_pc", {160'b0, out_pc1}, {160'b0, ep1});
      chk("m1_payload", {191'b0, out_payload1}, {191'b0, epay[0]});
      chk("m1_stall", {176'b0, stall_cnt1}, 192'(cnt1));
   endtask

   task automatic step(input bit r, input bit iv, input logic [31:0] pc,
                       input bit ordy, input bit fl);
      reset      = r;
      in_valid   = iv;
      in_pc      = pc;
      in_instr   = instr_of(pc);
      in_payload = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      out_ready  = ordy;
      flush      = fl;
      model_update();
      @(posedge clk);
      #1;
      model_check();
   endtask

   typedef struct {
      bit          rst, iv;
      logic [31:0] pc;
      bit          ordy, fl;
      bit          ev;
      logic [31:0] epc0, epc1;
      bit          erdy;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit rst, input bit iv, input logic [31:0] pc, input bit ordy,
                      input bit fl, input bit ev, input logic [31:0] epc0,
                      input logic [31:0] epc1, input bit erdy);
      vec_t v;
      v.rst = rst; v.iv = iv; v.pc = pc; v.ordy = ordy; v.fl = fl;
      v.ev = ev; v.epc0 = epc0; v.epc1 = epc1; v.erdy = erdy;
      tbl.push_back(v);
   endtask

   initial begin
      // rst iv pc ordy fl | ev epc0 epc1 erdy
      add(1, 0, 32'h0,    1, 0, 0, 32'h0,    32'h0,    1);
      for (int k = 0; k < 8; k++)
         add(0, 1, 32'h3000 + 4*k, 1, 0, 1, 32'h3000 + 4*k, 32'h3000 + 4*k, 1);
      add(0, 0, 32'h0,    1, 0, 0, 32'h301C, 32'h301C, 1);
      // back-pressure: A in M, B in S, C refused
      add(0, 1, 32'h3000, 0, 0, 1, 32'h3000, 32'h3000, 1);
      add(0, 1, 32'h3004, 0, 0, 1, 32'h3000, 32'h3000, 0);
      add(0, 1, 32'h3008, 0, 0, 1, 32'h3000, 32'h3000, 0);
      add(0, 0, 32'h0,    1, 0, 1, 32'h3004, 32'h3004, 1);
      add(0, 0, 32'h0,    1, 0, 0, 32'h3004, 32'h3004, 1);
      // flush with full skid
      add(0, 1, 32'h3000, 0, 0, 1, 32'h3000, 32'h3000, 1);
      add(0, 1, 32'h3004, 0, 0, 1, 32'h3000, 32'h3000, 0);
      add(0, 1, 32'h3008, 0, 1, 0, 32'h3000, 32'h0,    1);
      add(0, 0, 32'h0,    1, 0, 0, 32'h3000, 32'h0,    1);
      // flush coinciding with accept and drain
      add(0, 1, 32'h300C, 1, 0, 1, 32'h300C, 32'h300C, 1);
      add(0, 1, 32'h3010, 1, 1, 0, 32'h300C, 32'h0,    1);
      add(0, 0, 32'h0,    1, 0, 0, 32'h300C, 32'h0,    1);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].iv, tbl[i].pc, tbl[i].ordy, tbl[i].fl);
         chk("tbl_valid0", {191'b0, out_valid0}, {191'b0, tbl[i].ev});
         chk("tbl_valid1", {191'b0, out_valid1}, {191'b0, tbl[i].ev});
         chk("tbl_pc0", {160'b0, out_pc0}, {160'b0, tbl[i].epc0});
         chk("tbl_pc1", {160'b0, out_pc1}, {160'b0, tbl[i].epc1});
         chk("tbl_ready0", {191'b0, in_ready0}, {191'b0, tbl[i].erdy});
         if (i == 9) chk("tbl_stream_stall", {188'b0, stall_cnt0}, 192'd0);
      end

      // stall counter saturation
      step(1, 0, 32'h0, 1, 0);
      step(0, 1, 32'h5000, 0, 0);
      for (int k = 0; k < 20; k++) step(0, 0, 32'h0, 0, 0);
      chk("sat_cnt0", {188'b0, stall_cnt0}, 192'd15);
      chk("sat_cnt1", {176'b0, stall_cnt1}, 192'd20);
      step(1, 0, 32'h0, 0, 0);
      chk("sat_reset_cnt0", {188'b0, stall_cnt0}, 192'd0);

      // reset with M and S both full
      step(0, 1, 32'h6000, 0, 0);
      step(0, 1, 32'h6004, 0, 0);
      chk("pre_reset_ready", {191'b0, in_ready0}, 192'd0);
      step(1, 1, 32'h6008, 0, 0);
      chk("rst_valid", {191'b0, out_valid0}, 192'd0);
      chk("rst_instr", {160'b0, out_instr0}, 192'd0);
      chk("rst_pc", {160'b0, out_pc0}, 192'd0);
      chk("rst_payload", out_payload0, 192'd0);
      chk("rst_ready", {191'b0, in_ready0}, 192'd1);
      step(0, 1, 32'h4000, 1, 0);
      chk("post_rst_valid", {191'b0, out_valid0}, 192'd1);
      chk("post_rst_pc", {160'b0, out_pc0}, 192'h4000);
      step(0, 0, 32'h0, 1, 0);

      // randomised traffic with occasional flushes
      for (int k = 0; k < 10000; k++)
         step(0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 31) == 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
